// File: rtl/rr_grant_dispatch_if.sv
// Client/arbiter handshake bundle for rr_grant_dispatch.
// master = the dispatcher; slave = the clients and arbiter that surround it.
interface rr_grant_dispatch_if #(
    parameter int REQCNT   = 5,
    parameter int REQWIDTH = $clog2(REQCNT)
);
    logic [REQCNT-1:0]   req_pulse_i;
    logic [REQCNT-1:0]   req_o;
    logic                req_val_o;
    logic [REQWIDTH-1:0] req_num_i;
    logic                req_num_val_i;
    logic [REQCNT-1:0]   gnt_o;
    logic                gnt_val_o;
    logic [REQWIDTH-1:0] owner_o;
    logic                done_i;
    logic                busy_o;
    logic                tmo_o;
    logic                err_o;

    modport master (
        input  req_pulse_i, req_num_i, req_num_val_i, done_i,
        output req_o, req_val_o, gnt_o, gnt_val_o, owner_o, busy_o, tmo_o, err_o
    );

    modport slave (
        output req_pulse_i, req_num_i, req_num_val_i, done_i,
        input  req_o, req_val_o, gnt_o, gnt_val_o, owner_o, busy_o, tmo_o, err_o
    );
endinterface

// File: rtl/rr_grant_dispatch.sv
// Purpose: collect client request pulses, request the arbiter, decode its winner into one grant; RR_GNT_HOLD_EN holds gnt_o for the whole ownership.
// Latency: pulse->req_val 1 cycle; winner index->grant 1 cycle; done->release 1 cycle.
// Backpressure: one grant outstanding; requests keep accumulating while busy; a silent arbiter times out and is re-requested.
module rr_grant_dispatch #(
    parameter int REQCNT     = 5,
    parameter int REQWIDTH   = $clog2(REQCNT),
    parameter int TMO_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rr_grant_dispatch_if.master bus
);
    localparam int CW = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        BUSY     = 2'd2
    } state_t;

    state_t              state;
    logic [REQCNT-1:0]   pend;
    logic [REQCNT-1:0]   sel;
    logic [REQCNT-1:0]   clr;
    logic                grant_ok;
    logic [CW-1:0]       tmo_cnt;
    logic [REQCNT-1:0]   gnt;
    logic                gnt_val;
    logic [REQWIDTH-1:0] owner;
    logic                busy;
    logic                tmo;
    logic                err;

    // sel is all-zero for an out-of-range index, so such an index can never grant
    always_comb begin
        sel = '0;
        for (int i = 0; i < REQCNT; i++) begin
            sel[i] = (bus.req_num_i == REQWIDTH'(i));
        end
        grant_ok = (state == WAIT_GNT) && bus.req_num_val_i && (|(sel & pend));
        clr      = grant_ok ? sel : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            pend    <= '0;
            tmo_cnt <= '0;
            gnt     <= '0;
            gnt_val <= 1'b0;
            owner   <= '0;
            busy    <= 1'b0;
            tmo     <= 1'b0;
            err     <= 1'b0;
        end else begin
            pend    <= (pend & ~clr) | bus.req_pulse_i;
            gnt_val <= 1'b0;
            tmo     <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (bus.req_num_val_i) err <= 1'b1;
                    if (|pend) state <= WAIT_GNT;
                end
                WAIT_GNT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (bus.req_num_val_i) begin
                        if (grant_ok) begin
                            state   <= BUSY;
                            gnt     <= sel;
                            gnt_val <= 1'b1;
                            owner   <= bus.req_num_i;
                            busy    <= 1'b1;
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end else if (tmo_cnt == CW'(TMO_CYCLES - 1)) begin
                        tmo   <= 1'b1;
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (bus.req_num_val_i) err <= 1'b1;
`ifdef RR_GNT_HOLD_EN
                    gnt <= gnt;
`else
                    gnt <= '0;
`endif
                    if (bus.done_i) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        gnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_o     = pend;
    assign bus.req_val_o = (state == IDLE) && (|pend);
    assign bus.gnt_o     = gnt;
    assign bus.gnt_val_o = gnt_val;
    assign bus.owner_o   = owner;
    assign bus.busy_o    = busy;
    assign bus.tmo_o     = tmo;
    assign bus.err_o     = err;
endmodule

// File: doc/rr_grant_dispatch.md
Name: rr_grant_dispatch

Overview:
Requester-side companion to the round-robin arbiter.
- Collects per-client request pulses into a pending vector and presents it to the arbiter as req/req_val.
- Accepts the arbiter's winning index (req_num/req_num_val), decodes it into a one-hot grant and clears the winner's pending bit.
- Holds ownership until the granted client signals done.
- Sits between the client ports and the arbiter; one grant is outstanding at a time.

Parameters:
- REQCNT, 5, number of clients / width of the request vector.
- REQWIDTH, $clog2(REQCNT), width of the arbiter index.
- TMO_CYCLES, 16, maximum number of cycles spent in WAIT_GNT before retrying (minimum 2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_pulse_i  in  REQCNT  per-client one-cycle request pulses; sets the pending bit.
- req_o  out  REQCNT  pending vector, driven to the arbiter req_i.
- req_val_o  out  1  request-valid strobe to the arbiter.
- req_num_i  in  REQWIDTH  winning index from the arbiter.
- req_num_val_i  in  1  winning index valid.
- gnt_o  out  REQCNT  one-hot grant to the clients.
- gnt_val_o  out  1  grant strobe.
- owner_o  out  REQWIDTH  index of the current owner, valid while busy_o is high.
- done_i  in  1  owner releases the resource.
- busy_o  out  1  resource owned.
- tmo_o  out  1  one-cycle pulse on arbitration timeout.
- err_o  out  1  sticky error flag.

Behaviour:
Reset:
- The interface is one clock; reset is synchronous and active-high.
- When rst_i is sampled high, all state and outputs clear at that edge: pend=0, state=IDLE, tmo counter=0, owner=0, gnt_o=0, gnt_val_o=0, busy_o=0, tmo_o=0, err_o=0.
- Reset mid-operation drops pending requests and any ownership.

Pending register:
- pend_next = (pend & ~clr) | req_pulse_i, where clr is the one-hot of an accepted grant.
- A new pulse on the bit being granted in the same cycle is therefore retained.
- req_o = pend, registered.

FSM states: IDLE, WAIT_GNT, BUSY.

IDLE:
- req_val_o = (pend != 0), combinational.
- If pend != 0, go to WAIT_GNT next cycle and clear the timeout counter.
- Latency: a pulse at cycle N makes req_o and req_val_o high at N+1; the state is WAIT_GNT at N+2.

WAIT_GNT:
- req_val_o = 0.
- The counter increments each cycle.
- req_num_val_i=1 with req_num_i < REQCNT and pend[req_num_i]=1, at cycle M:
  - at M+1: gnt_o = 1<<req_num_i, owner_o = req_num_i, busy_o = 1, and the pend bit is cleared;
  - go to BUSY.
- req_num_val_i=1 with an index >= REQCNT, or with a non-pending bit:
  - set err_o;
  - go to IDLE with no grant.
- Counter reaches TMO_CYCLES-1 with no req_num_val_i:
  - tmo_o pulses for one cycle;
  - go to IDLE, which re-requests on the next cycle if pend is nonzero.
- If req_num_val_i and the timeout coincide, the grant wins.

BUSY:
- busy_o = 1 and owner_o is held.
- gnt_val_o is a one-cycle pulse on the first BUSY cycle; gnt_o is zero after that cycle.
- done_i sampled at cycle K: go to IDLE at K+1, and busy_o is low at K+1.
- done_i is honoured on the first BUSY cycle.
- req_pulse_i keeps accumulating into pend during BUSY.

Ignored inputs:
- done_i outside BUSY is ignored.
- req_num_val_i in IDLE or BUSY is ignored and sets err_o.

err_o:
- Cleared only by reset.

Optional Feature:
RR_GNT_HOLD_EN
- Defined: gnt_o stays at the owner one-hot for every BUSY cycle and clears in the cycle busy_o falls; gnt_val_o still pulses once.
- Undefined: gnt_o is nonzero only in the gnt_val_o cycle.

Test Plan:
- Reset, then req_pulse_i=5'b00100 at cycle 3 -> req_o=00100 and req_val_o=1 at cycle 4; req_num_i=2 with req_num_val_i at cycle 6 -> gnt_o=00100, gnt_val_o=1, busy_o=1, owner_o=2 at cycle 7, and req_o=0.
- In BUSY, pulse bits 0 and 4; done_i at cycle 10 -> IDLE at 11, req_val_o=1 with req_o=10001 at 11; index 4 granted -> req_o=00001 afterwards.
- req_val_o issued, then no req_num_val_i for 16 cycles -> tmo_o pulse, back to IDLE, req_val_o reasserted the following cycle, pend unchanged.
- In WAIT_GNT, req_num_i=6 (>= REQCNT) or an index whose pend bit is 0 -> err_o=1 sticky, no gnt_val_o, return to IDLE.
- Pulse on bit 1 in the same cycle bit 1 is granted -> pend[1] stays 1 after the grant; separately, assert rst_i during BUSY -> all outputs 0 next cycle.
- With RR_GNT_HOLD_EN defined: grant index 3, done_i 5 cycles later -> gnt_o=01000 for all 5 BUSY cycles and 0 when busy_o falls; without the macro -> gnt_o=01000 for one cycle only.
